// File: rtl/cache_pkg.sv
// Shared constants and encodings for the cache-to-memory request arbiter.
// Holds width defaults, FSM state encoding and read/write encoding.
package cache_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_LINE_W = 128;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/mem_req_arbiter_if.sv
// Bundle of both cache request ports and the memory port of the arbiter.
// The slave modport is the arbiter; the master modport is the caches plus memory.
interface mem_req_arbiter_if
    import cache_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LINE_W = DEF_LINE_W
);
    logic [ADDR_W-1:0] req0_addr,  req1_addr;
    logic [LINE_W-1:0] req0_wdata, req1_wdata;
    logic              req0_rw,    req1_rw;
    logic              req0_valid, req1_valid;
    logic [LINE_W-1:0] req0_rdata, req1_rdata;
    logic              req0_ready, req1_ready;

    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_rw;
    logic              mem_valid;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_ready;

    modport slave (
        input  req0_addr, req0_wdata, req0_rw, req0_valid,
        input  req1_addr, req1_wdata, req1_rw, req1_valid,
        output req0_rdata, req0_ready, req1_rdata, req1_ready,
        output mem_addr, mem_wdata, mem_rw, mem_valid,
        input  mem_rdata, mem_ready
    );

    modport master (
        output req0_addr, req0_wdata, req0_rw, req0_valid,
        output req1_addr, req1_wdata, req1_rw, req1_valid,
        input  req0_rdata, req0_ready, req1_rdata, req1_ready,
        input  mem_addr, mem_wdata, mem_rw, mem_valid,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: with both ports pending, the port not granted last wins.
module rr_arb2 (
    input  logic [1:0] pend,
    input  logic       last_grant,
    output logic       grant,
    output logic       grant_valid
);

    // NOTE: every output gets a default before any branch, so no latch is inferred.
    always_comb begin
        grant       = 1'b0;
        grant_valid = |pend;
        if (&pend)
            grant = ~last_grant;
        else
            grant = pend[1];
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Captures pulsed requests from I-cache (port 0) and D-cache (port 1) and
// serialises them round-robin onto a single line-wide memory port.
module mem_req_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_req_arbiter_if.slave  bus,
    output logic              timeout_err,
    output logic              proto_err
);

    localparam int              TW    = $clog2(TIMEOUT);
    localparam logic [TW-1:0]   TLAST = TW'(TIMEOUT - 1);

    logic [1:0]        req_valid;
    logic [ADDR_W-1:0] req_addr  [2];
    logic [LINE_W-1:0] req_wdata [2];
    logic [1:0]        req_rw;

    logic [ADDR_W-1:0] slot_addr  [2];
    logic [LINE_W-1:0] slot_wdata [2];
    logic [1:0]        slot_rw;

    arb_state_e        state;
    logic [1:0]        pend;
    logic [1:0]        ready_q;
    logic [LINE_W-1:0] rdata_q [2];
    logic              last_grant;
    logic [TW-1:0]     timer;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [LINE_W-1:0] mem_wdata_q;
    logic              mem_rw_q;
    logic              mem_valid_q;
    logic              grant;
    logic              grant_valid;

    assign req_valid    = {bus.req1_valid, bus.req0_valid};
    assign req_rw       = {bus.req1_rw, bus.req0_rw};
    assign req_addr[0]  = bus.req0_addr;
    assign req_addr[1]  = bus.req1_addr;
    assign req_wdata[0] = bus.req0_wdata;
    assign req_wdata[1] = bus.req1_wdata;

    assign bus.req0_rdata = rdata_q[0];
    assign bus.req1_rdata = rdata_q[1];
    assign bus.req0_ready = ready_q[0];
    assign bus.req1_ready = ready_q[1];
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_rw     = mem_rw_q;
    assign bus.mem_valid  = mem_valid_q;

    rr_arb2 u_rr_arb2 (
        .pend        (pend),
        .last_grant  (last_grant),
        .grant       (grant),
        .grant_valid (grant_valid)
    );

    // NOTE: request slots carry no reset; they are only read while their pend bit is set.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (req_valid[p] && !pend[p]) begin
                slot_addr[p]  <= req_addr[p];
                slot_wdata[p] <= req_wdata[p];
                slot_rw[p]    <= req_rw[p];
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            pend        <= 2'b00;
            ready_q     <= 2'b11;
            rdata_q[0]  <= '0;
            rdata_q[1]  <= '0;
            last_grant  <= 1'b1;
            timer       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rw_q    <= 1'b0;
            mem_valid_q <= 1'b0;
            timeout_err <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            proto_err   <= |(req_valid & pend);
            timeout_err <= 1'b0;

            for (int p = 0; p < 2; p++) begin
                if (req_valid[p] && !pend[p]) begin
                    pend[p]    <= 1'b1;
                    ready_q[p] <= 1'b0;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        mem_addr_q  <= slot_addr[grant];
                        mem_wdata_q <= slot_wdata[grant];
                        mem_rw_q    <= slot_rw[grant];
                        mem_valid_q <= 1'b1;
                        last_grant  <= grant;
                        state       <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    mem_valid_q <= 1'b0;
                    timer       <= '0;
                    state       <= ST_WAIT;
                end
                ST_WAIT: begin
                    // last_grant names the port owning the transaction in flight
                    if (!mem_valid_q && bus.mem_ready) begin
                        if (mem_rw_q == RW_READ)
                            rdata_q[last_grant] <= bus.mem_rdata;
                        pend[last_grant]    <= 1'b0;
                        ready_q[last_grant] <= 1'b1;
                        timer               <= '0;
                        state               <= ST_IDLE;
                    end else if (timer == TLAST) begin
                        if (mem_rw_q == RW_READ)
                            rdata_q[last_grant] <= '0;
                        pend[last_grant]    <= 1'b0;
                        ready_q[last_grant] <= 1'b1;
                        timeout_err         <= 1'b1;
                        timer               <= '0;
                        state               <= ST_IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
